rgb_to_grey: RTL

//  Converts a 24-bit RGB pixel stream to luminance ahead of the image-gradient stage.

---
 rtl/rgb_to_grey_if.sv | 27 ++
 rtl/rgb_to_grey.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/rgb_to_grey_if.sv
`default_nettype none
//==============================================================================
// Module   : rgb_to_grey_if
// Brief    : Point-to-point pixel stream (vld / data / busy) used on both sides
//            of the RGB-to-luminance converter.
// Revision : 1.0 - initial release
//==============================================================================
interface rgb_to_grey_if;
    logic        vld;   // producer has a pixel this cycle
    logic [23:0] data;  // pixel payload
    logic        busy;  // consumer cannot take a pixel this cycle

    // Producer side: drives the pixel, observes backpressure
    modport master (
        output vld,
        output data,
        input  busy
    );

    // Consumer side: observes the pixel, drives backpressure
    modport slave (
        input  vld,
        input  data,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/rgb_to_grey.sv
`default_nettype none
//==============================================================================
// Module   : rgb_to_grey
// Brief    : 24-bit RGB stream to luminance {Y,Y,Y}. Products are registered in
//            S1, the weighted sum is formed in the following cycle (S2) and
//            written straight into a small output FIFO. Upstream acceptance is
//            governed by credits (FIFO occupancy + in-flight pixel), so the
//            arithmetic never stalls. Raster counters on the output side flag
//            the end of each frame.
// Revision : 1.0 - initial release
//==============================================================================
module rgb_to_grey #(
    parameter int IMG_W      = 256,
    parameter int IMG_H      = 256,
    parameter int FIFO_DEPTH = 4,
    parameter int COEF_R     = 77,
    parameter int COEF_G     = 150,
    parameter int COEF_B     = 29
) (
    input  logic          i_clk,
    input  logic          i_rst,        // asynchronous, active-low
    rgb_to_grey_if.slave  i_rgb,
    rgb_to_grey_if.master o_grey,
    output logic          o_frame_done
);

    //--------------------------------------------------------------------------
    // Derived widths and typed constants
    //--------------------------------------------------------------------------
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [PTR_W-1:0] C_PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W:0]   C_CREDITS  = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [COL_W-1:0] C_COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] C_ROW_LAST = ROW_W'(IMG_H - 1);

    // Weights sum to 256, so a single weight can reach 256 and needs 9 bits.
    localparam logic [8:0] C_COEF_R = 9'(COEF_R);
    localparam logic [8:0] C_COEF_G = 9'(COEF_G);
    localparam logic [8:0] C_COEF_B = 9'(COEF_B);
    localparam logic [16:0] C_ROUND = 17'd128;

    //--------------------------------------------------------------------------
    // State
    //--------------------------------------------------------------------------
    logic                    s1_vld_q, s1_vld_d;
    logic [15:0]             pr_q, pr_d;
    logic [15:0]             pg_q, pg_d;
    logic [15:0]             pb_q, pb_d;

    logic [7:0]              mem_q [FIFO_DEPTH];
    logic [7:0]              mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;

    logic [COL_W-1:0]        col_q, col_d;
    logic [ROW_W-1:0]        row_q, row_d;
    logic                    frame_done_q, frame_done_d;

    //--------------------------------------------------------------------------
    // Handshake terms
    //--------------------------------------------------------------------------
    logic                    rgb_busy_w;
    logic                    accept_w;
    logic                    push_w;
    logic                    pop_w;
    logic                    grey_vld_w;
    logic [CNT_W:0]          in_use_w;
    logic [16:0]             sum_w;
    logic [7:0]              y_w;

    // The S2 sum is combinational on the S1 registers, so S1 is the only
    // in-flight slot; every S1 pixel owns a FIFO entry one edge later.
    assign in_use_w   = {1'b0, count_q} + {{CNT_W{1'b0}}, s1_vld_q};
    assign rgb_busy_w = (in_use_w >= C_CREDITS);
    assign accept_w   = i_rgb.vld & ~rgb_busy_w;
    assign push_w     = s1_vld_q;
    assign grey_vld_w = (count_q != '0);
    assign pop_w      = grey_vld_w & ~o_grey.busy;

    assign i_rgb.busy   = rgb_busy_w;
    assign o_grey.vld   = grey_vld_w;
    assign o_grey.data  = grey_vld_w ? {3{mem_q[rd_ptr_q]}} : 24'd0;
    assign o_frame_done = frame_done_q;

    //--------------------------------------------------------------------------
    // S1: weight each channel as soon as a pixel is accepted
    //--------------------------------------------------------------------------
    // S1 next-state: load products on accept, otherwise hold
    always_comb begin
        s1_vld_d = accept_w;
        pr_d     = pr_q;
        pg_d     = pg_q;
        pb_d     = pb_q;
        if (accept_w) begin
            pr_d = {8'd0, i_rgb.data[23:16]} * {7'd0, C_COEF_R};
            pg_d = {8'd0, i_rgb.data[15:8]}  * {7'd0, C_COEF_G};
            pb_d = {8'd0, i_rgb.data[7:0]}   * {7'd0, C_COEF_B};
        end
    end

    // S1 registers
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            s1_vld_q <= 1'b0;
            pr_q     <= '0;
            pg_q     <= '0;
            pb_q     <= '0;
        end else begin
            s1_vld_q <= s1_vld_d;
            pr_q     <= pr_d;
            pg_q     <= pg_d;
            pb_q     <= pb_d;
        end
    end

    //--------------------------------------------------------------------------
    // S2: rounded sum; weights total 256 so the top bit is never set for
    // 8-bit inputs and Y tops out at 255 without saturation logic.
    //--------------------------------------------------------------------------
    // Rounded weighted sum feeding the FIFO write port
    always_comb begin
        sum_w = {1'b0, pr_q} + {1'b0, pg_q} + {1'b0, pb_q} + C_ROUND;
        y_w   = 8'(sum_w >> 8);
    end

    //--------------------------------------------------------------------------
    // Output FIFO
    //--------------------------------------------------------------------------
    // FIFO next-state: write S2 result, pop on transfer, track occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_w) begin
            mem_d[wr_ptr_q] = y_w;
            wr_ptr_d        = (wr_ptr_q == C_PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop_w) begin
            rd_ptr_d = (rd_ptr_q == C_PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({push_w, pop_w})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO registers; reset empties the queue and discards stored pixels
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    //--------------------------------------------------------------------------
    // Raster position of the next pixel to leave; advances on transfer only
    //--------------------------------------------------------------------------
    // Frame counter next-state and end-of-frame detection
    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        frame_done_d = 1'b0;
        if (pop_w) begin
            if (col_q == C_COL_LAST) begin
                col_d = '0;
                if (row_q == C_ROW_LAST) begin
                    row_d        = '0;
                    frame_done_d = 1'b1;
                end else begin
                    row_d = row_q + ROW_W'(1);
                end
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    // Frame counter registers and the one-cycle end-of-frame pulse
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            col_q        <= '0;
            row_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule
`default_nettype wire
